// File: rtl/fixp_window_averager.sv
// Window averager for the Q3.12 adder stream: gathers non-overlapping windows
// of 2^LOG2_WINDOW signed samples and emits either the rounded mean or the
// saturated sum per window over a valid/ready output.
module fixp_window_averager #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 12,
  parameter int LOG2_WINDOW = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [WIDTH-1:0]       io_in_bits,
  input  logic                   io_mode_sum,
  input  logic                   io_flush,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [WIDTH-1:0]       io_out_bits,
  output logic                   io_out_sat,
  output logic [LOG2_WINDOW-1:0] io_count
);

  // Accumulator is wide enough that a full window of extreme samples never wraps.
  localparam int AW = WIDTH + LOG2_WINDOW;

  localparam logic [LOG2_WINDOW-1:0] C_CNT_LAST = {LOG2_WINDOW{1'b1}};
  localparam logic [LOG2_WINDOW-1:0] C_CNT_ONE  = LOG2_WINDOW'(1'b1);
  localparam logic [LOG2_WINDOW-1:0] C_CNT_ZERO = {LOG2_WINDOW{1'b0}};
  localparam logic signed [AW-1:0]   C_ACC_ZERO = {AW{1'b0}};
  localparam logic signed [AW-1:0]   C_HALF     = AW'(1'b1) << (LOG2_WINDOW - 1);
  localparam logic signed [AW-1:0]   C_MAX      = {{(LOG2_WINDOW + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0]   C_MIN      = {{(LOG2_WINDOW + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Reject parameter sets the arithmetic was not sized for.
  if (LOG2_WINDOW < 1 || LOG2_WINDOW > 6 || FRAC_BITS >= WIDTH) begin : g_bad_param
    $error("fixp_window_averager: LOG2_WINDOW must be 1..6 and FRAC_BITS < WIDTH");
  end

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [AW-1:0]     r_acc;
  logic [LOG2_WINDOW-1:0]   r_count;
  logic                     r_mode;
  logic [WIDTH-1:0]         r_out_bits;
  logic                     r_out_sat;

  logic                     w_in_ready;
  logic                     w_fire;
  logic                     w_last;
  logic                     w_mode;
  logic signed [AW-1:0]     w_sum;
  logic [WIDTH-1:0]         w_mean;
  logic [WIDTH:0]           w_sat_pack;
  logic [WIDTH-1:0]         w_res_bits;
  logic                     w_res_sat;

  // Clamp a wide sum into the output range; MSB of the result flags clamping.
  function automatic logic [WIDTH:0] sat_sum(input logic signed [AW-1:0] s);
    logic [WIDTH:0] res;
    if (s > C_MAX) begin
      res = {1'b1, C_MAX[WIDTH-1:0]};
    end else if (s < C_MIN) begin
      res = {1'b1, C_MIN[WIDTH-1:0]};
    end else begin
      res = {1'b0, s[WIDTH-1:0]};
    end
    return res;
  endfunction

  assign w_in_ready = (r_state == ST_ACCUM) && !io_flush;
  assign w_fire     = io_in_valid && w_in_ready;
  assign w_last     = (r_count == C_CNT_LAST);
  assign w_sum      = r_acc + {{LOG2_WINDOW{io_in_bits[WIDTH-1]}}, io_in_bits};
  // The first sample of a window uses the live mode input, later ones the latched copy.
  assign w_mode     = (r_count == C_CNT_ZERO) ? io_mode_sum : r_mode;
  // Round half up, then arithmetic shift; the quotient always fits in WIDTH bits.
  assign w_mean     = WIDTH'((w_sum + C_HALF) >>> LOG2_WINDOW);
  assign w_sat_pack = sat_sum(w_sum);

  // Select the window result according to the latched mode.
  always_comb begin
    w_res_bits = w_mean;
    w_res_sat  = 1'b0;
    if (w_mode) begin
      w_res_bits = w_sat_pack[WIDTH-1:0];
      w_res_sat  = w_sat_pack[WIDTH];
    end else begin
      w_res_bits = w_mean;
      w_res_sat  = 1'b0;
    end
  end

  // Next-state logic: leave ACCUM on the last sample, leave OUT on handshake or flush.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_fire && w_last) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_OUT: begin
        if (io_flush || io_out_ready) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, sample counter, mode latch and registered result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc      <= C_ACC_ZERO;
      r_count    <= C_CNT_ZERO;
      r_mode     <= 1'b0;
      r_out_bits <= {WIDTH{1'b0}};
      r_out_sat  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (io_flush) begin
            r_acc   <= C_ACC_ZERO;
            r_count <= C_CNT_ZERO;
          end else if (w_fire) begin
            if (r_count == C_CNT_ZERO) begin
              r_mode <= io_mode_sum;
            end
            if (w_last) begin
              r_out_bits <= w_res_bits;
              r_out_sat  <= w_res_sat;
              r_acc      <= C_ACC_ZERO;
              r_count    <= C_CNT_ZERO;
            end else begin
              r_acc   <= w_sum;
              r_count <= r_count + C_CNT_ONE;
            end
          end
        end
        ST_OUT: begin
          r_acc   <= C_ACC_ZERO;
          r_count <= C_CNT_ZERO;
        end
        default: begin
          r_acc   <= C_ACC_ZERO;
          r_count <= C_CNT_ZERO;
        end
      endcase
    end
  end

  assign io_in_ready  = w_in_ready;
  assign io_out_valid = (r_state == ST_OUT);
  assign io_out_bits  = r_out_bits;
  assign io_out_sat   = r_out_sat;
  assign io_count     = r_count;

endmodule

// File: tb/tb_fixp_window_averager.sv
// Self-checking bench for fixp_window_averager: directed test-plan windows with
// literal expectations plus a randomized phase, all cross-checked every cycle
// against a window-level behavioural model.
module tb_fixp_window_averager;

  localparam int W  = 16;
  localparam int LW = 2;
  localparam int N  = 1 << LW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_in_valid = 1'b0;
  logic          io_in_ready;
  logic [W-1:0]  io_in_bits = '0;
  logic          io_mode_sum = 1'b0;
  logic          io_flush = 1'b0;
  logic          io_out_valid;
  logic          io_out_ready = 1'b0;
  logic [W-1:0]  io_out_bits;
  logic          io_out_sat;
  logic [LW-1:0] io_count;

  fixp_window_averager #(.WIDTH(W), .FRAC_BITS(12), .LOG2_WINDOW(LW)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_mode_sum(io_mode_sum), .io_flush(io_flush),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits(io_out_bits), .io_out_sat(io_out_sat), .io_count(io_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (window level) ----------------
  bit m_pending = 1'b0;
  int m_win[$];
  bit m_mode    = 1'b0;
  int m_bits    = 0;
  bit m_sat     = 1'b0;
  int m_results = 0;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    else return -((-a + b - 1) / b);
  endfunction

  always @(posedge clock) begin
    int sum;
    if (reset) begin
      m_pending = 1'b0;
      m_win.delete();
      m_bits = 0;
      m_sat  = 1'b0;
      m_mode = 1'b0;
    end else if (!m_pending) begin
      if (io_flush) begin
        m_win.delete();
      end else if (io_in_valid) begin
        if (m_win.size() == 0) m_mode = io_mode_sum;
        m_win.push_back(int'($signed(io_in_bits)));
        if (m_win.size() == N) begin
          sum = 0;
          foreach (m_win[k]) sum += m_win[k];
          if (m_mode) begin
            if (sum > 32767) begin m_bits = 32767; m_sat = 1'b1; end
            else if (sum < -32768) begin m_bits = -32768; m_sat = 1'b1; end
            else begin m_bits = sum; m_sat = 1'b0; end
          end else begin
            m_bits = floor_div(sum + N / 2, N);
            m_sat  = 1'b0;
          end
          m_pending = 1'b1;
          m_results++;
          m_win.delete();
        end
      end
    end else begin
      if (io_flush || io_out_ready) m_pending = 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready",  int'(io_in_ready),  int'(!m_pending && !io_flush));
      check("out_valid", int'(io_out_valid), int'(m_pending));
      check("count",     int'(io_count),     m_win.size());
      check("out_bits",  int'($signed(io_out_bits)), m_bits);
      check("out_sat",   int'(io_out_sat),   int'(m_sat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a sample and wait (bounded) until it is accepted; valid is left high.
  task automatic send_sample(input int v, input bit mode);
    bit got;
    int guard;
    io_in_valid = 1'b1;
    io_in_bits  = W'(v);
    io_mode_sum = mode;
    guard = 0;
    forever begin
      @(negedge clock);
      got = io_in_ready;
      tick();
      if (got) break;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] a16, b16, c16, d16;
    a16 = a[15:0]; b16 = b[15:0]; c16 = c[15:0]; d16 = d[15:0];
    return {d16, c16, b16, a16};
  endfunction

  // One full window with out_ready high; result must appear for exactly one cycle.
  task automatic run_window(input string name, input logic [63:0] s, input logic [3:0] modes,
                            input int exp_bits, input int exp_sat);
    logic [15:0] v;
    io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = s[16*i +: 16];
      send_sample(int'($signed(v)), modes[i]);
    end
    io_in_valid = 1'b0;
    @(negedge clock);
    check({name, "_valid"}, int'(io_out_valid), 1);
    check({name, "_bits"},  int'($signed(io_out_bits)), exp_bits);
    check({name, "_sat"},   int'(io_out_sat), exp_sat);
    check({name, "_model"}, m_bits, exp_bits);
    tick();
    @(negedge clock);
    check({name, "_valid_fall"}, int'(io_out_valid), 0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int r;
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", int'(io_out_valid), 0);
    check("rst_bits",  int'(io_out_bits), 0);
    check("rst_sat",   int'(io_out_sat), 0);
    check("rst_count", int'(io_count), 0);
    check("rst_ready", int'(io_in_ready), 1);
    tick();

    // Mean / sum basics
    run_window("mean_zero",  pack4(9012, -9012, -3276, 3276), 4'b0000, 0, 0);
    run_window("mean_9012",  pack4(9012, 9012, 9012, 9012),   4'b0000, 9012, 0);
    run_window("sum_pos",    pack4(9012, 9012, 9012, 9012),   4'b1111, 32767, 1);
    run_window("sum_neg",    pack4(-9012, -9012, -9012, -9012), 4'b1111, -32768, 1);
    run_window("sum_257",    pack4(100, 200, -50, 7),         4'b1111, 257, 0);
    // Rounding
    run_window("rnd_p1",     pack4(1, 0, 0, 0),    4'b0000, 0, 0);
    run_window("rnd_p2",     pack4(2, 0, 0, 0),    4'b0000, 1, 0);
    run_window("rnd_m2",     pack4(-2, 0, 0, 0),   4'b0000, 0, 0);
    run_window("rnd_m3",     pack4(-3, 0, 0, 0),   4'b0000, -1, 0);
    run_window("rnd_4506",   pack4(4506, 0, 0, 0), 4'b0000, 1127, 0);

    // Backpressure with input valid held high
    io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_sample(1000, 1'b0);
    io_in_bits = 16'd500;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_valid", int'(io_out_valid), 1);
      check("bp_bits",  int'($signed(io_out_bits)), 1000);
      check("bp_ready", int'(io_in_ready), 0);
      tick();
    end
    io_out_ready = 1'b1;
    tick();
    @(negedge clock);
    check("bp_ready_after", int'(io_in_ready), 1);
    tick();
    for (int i = 0; i < 3; i++) send_sample(500, 1'b0);
    io_in_valid = 1'b0;
    @(negedge clock);
    check("bp_next_valid", int'(io_out_valid), 1);
    check("bp_next_bits",  int'($signed(io_out_bits)), 500);
    tick();

    // Flush in ACCUM
    send_sample(5000, 1'b0);
    send_sample(5000, 1'b0);
    io_in_valid = 1'b0;
    @(negedge clock);
    check("fl_count_pre", int'(io_count), 2);
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    @(negedge clock);
    check("fl_count_post", int'(io_count), 0);
    tick();
    run_window("fl_result", pack4(100, 100, 100, 100), 4'b0000, 100, 0);

    // Flush in OUT wins over out_ready
    io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_sample(2000, 1'b0);
    io_in_valid = 1'b0;
    @(negedge clock);
    check("flo_valid", int'(io_out_valid), 1);
    held = io_out_bits;
    io_flush = 1'b1;
    io_out_ready = 1'b1;
    tick();
    io_flush = 1'b0;
    @(negedge clock);
    check("flo_dropped", int'(io_out_valid), 0);
    check("flo_bits_hold", int'($signed(io_out_bits)), 2000);
    tick();

    // Reset mid-window, then mode latched at window start
    for (int i = 0; i < 3; i++) send_sample(777, 1'b0);
    io_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("mrst_valid", int'(io_out_valid), 0);
    check("mrst_bits",  int'(io_out_bits), 0);
    check("mrst_sat",   int'(io_out_sat), 0);
    check("mrst_count", int'(io_count), 0);
    reset = 1'b0;
    tick();
    run_window("mode_latch", pack4(-1638, -1638, -1638, -1638), 4'b1110, -1638, 0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      io_flush     = ($urandom_range(0, 19) == 0);
      io_in_valid  = ($urandom_range(0, 3) != 0);
      io_out_ready = $urandom_range(0, 1);
      io_mode_sum  = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      case (r)
        0: io_in_bits = 16'h7FFF - W'($urandom_range(0, 3));
        1: io_in_bits = 16'h8000 + W'($urandom_range(0, 3));
        2: io_in_bits = W'($urandom_range(0, 15)) - 16'd8;
        default: io_in_bits = W'($urandom);
      endcase
      tick();
    end
    reset = 1'b0;
    io_flush = 1'b0;
    io_in_valid = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
